// File: rtl/serdes_pkg.sv
// Shared SerDes receive-side definitions: K28.5 patterns, link FSM states and
// CDR loop-filter gain codes.
package serdes_pkg;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  localparam logic [1:0] GAIN_ACQ = 2'b11;
  localparam logic [1:0] GAIN_TRK = 2'b01;

  // Number of distinct bit rotations of a 10-bit word.
  localparam int SLIP_ROTATIONS = 10;

  typedef enum logic [2:0] {
    CDR_ACQ      = 3'd0,
    COMMA_SEARCH = 3'd1,
    SLIP_HOLD    = 3'd2,
    COMMA_VERIFY = 3'd3,
    LINK_UP      = 3'd4
  } rx_link_state_e;

  // Magnitude of the difference of two phase words, widened so it cannot wrap.
  function automatic logic [9:0] abs_delta(input logic [8:0] a, input logic [8:0] b);
    if (a >= b) return {1'b0, a} - {1'b0, b};
    else        return {1'b0, b} - {1'b0, a};
  endfunction

endpackage

// File: rtl/comma_detector.sv
// Combinational K28.5 match on a raw 10-bit word, either running disparity.
module comma_detector
  import serdes_pkg::*;
(
  input  logic [9:0] rx_word,
  output logic       is_comma
);

  assign is_comma = (rx_word == K28_5_RDN) || (rx_word == K28_5_RDP);

endmodule

// File: rtl/rx_link_controller.sv
// Rx link bring-up sequencer: CDR settle, comma alignment via BitSlip, link
// monitoring. Define RX_LINK_STATS_EN to add link_drops/slip_total counters.
module rx_link_controller
  import serdes_pkg::*;
#(
  parameter int SETTLE_CYCLES = 64,
  parameter int STABLE_TOL    = 4,
  parameter int SEARCH_WORDS  = 32,
  parameter int SLIP_WAIT     = 3,
  parameter int LOCK_COMMAS   = 4,
  parameter int ERR_LIMIT     = 8,
  parameter int ERR_WINDOW    = 256
) (
  input  logic        BitCLK_10,
  input  logic        Reset,
  input  logic [9:0]  RxParallel_10,
  input  logic        DecodeErr,
  input  logic [8:0]  phase_shift,
  output logic        BitSlip,
  output logic [1:0]  gainsel,
  output logic        Aligned,
  output logic        LinkUp,
  output logic [2:0]  state_dbg
`ifdef RX_LINK_STATS_EN
  ,
  output logic [15:0] link_drops,
  output logic [15:0] slip_total
`endif
);

  localparam int STAB_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int SRCH_W  = $clog2(SEARCH_WORDS + 1);
  localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);
  localparam int COMMA_W = $clog2(LOCK_COMMAS + 1);
  localparam int WIN_W   = $clog2(ERR_WINDOW);
  localparam int ERR_W   = $clog2(ERR_LIMIT + 1);

  rx_link_state_e state_reg, state_next;
  logic [STAB_W-1:0]  stab_cnt_reg, stab_cnt_next;
  logic [SRCH_W-1:0]  search_cnt_reg, search_cnt_next;
  logic [SRCH_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [WAIT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic [COMMA_W-1:0] comma_cnt_reg, comma_cnt_next;
  logic [3:0]         slip_cnt_reg, slip_cnt_next;
  logic [WIN_W-1:0]   win_cnt_reg, win_cnt_next;
  logic [ERR_W-1:0]   err_cnt_reg, err_cnt_next;
  logic [8:0]         prev_phase_reg;
  logic               prev_valid_reg;
  logic               bit_slip_reg, bit_slip_next;
  logic [1:0]         gain_reg, gain_next;
  logic               aligned_reg, aligned_next;
  logic               link_up_reg, link_up_next;

  logic             is_comma;
  logic             stable;
  logic [ERR_W:0]   err_sum;
  logic             win_wrap;

  comma_detector u_comma_detector (
    .rx_word  (RxParallel_10),
    .is_comma (is_comma)
  );

  // The first word after reset has no reference and counts as stable.
  assign stable   = !prev_valid_reg ||
                    (abs_delta(phase_shift, prev_phase_reg) <= 10'(STABLE_TOL));
  assign err_sum  = {1'b0, err_cnt_reg} + (ERR_W+1)'(DecodeErr);
  assign win_wrap = (win_cnt_reg == WIN_W'(ERR_WINDOW - 1));

  always_ff @(posedge BitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      state_reg      <= CDR_ACQ;
      stab_cnt_reg   <= '0;
      search_cnt_reg <= '0;
      gap_cnt_reg    <= '0;
      wait_cnt_reg   <= '0;
      comma_cnt_reg  <= '0;
      slip_cnt_reg   <= '0;
      win_cnt_reg    <= '0;
      err_cnt_reg    <= '0;
      prev_phase_reg <= '0;
      prev_valid_reg <= 1'b0;
      bit_slip_reg   <= 1'b0;
      gain_reg       <= GAIN_ACQ;
      aligned_reg    <= 1'b0;
      link_up_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      stab_cnt_reg   <= stab_cnt_next;
      search_cnt_reg <= search_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      comma_cnt_reg  <= comma_cnt_next;
      slip_cnt_reg   <= slip_cnt_next;
      win_cnt_reg    <= win_cnt_next;
      err_cnt_reg    <= err_cnt_next;
      prev_phase_reg <= phase_shift;
      prev_valid_reg <= 1'b1;
      bit_slip_reg   <= bit_slip_next;
      gain_reg       <= gain_next;
      aligned_reg    <= aligned_next;
      link_up_reg    <= link_up_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    stab_cnt_next   = stab_cnt_reg;
    search_cnt_next = search_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    wait_cnt_next   = wait_cnt_reg;
    comma_cnt_next  = comma_cnt_reg;
    slip_cnt_next   = slip_cnt_reg;
    win_cnt_next    = win_cnt_reg;
    err_cnt_next    = err_cnt_reg;
    bit_slip_next   = 1'b0;
    gain_next       = gain_reg;
    aligned_next    = aligned_reg;
    link_up_next    = link_up_reg;

    case (state_reg)
      CDR_ACQ: begin
        if (!stable) begin
          stab_cnt_next = '0;
        end else if (stab_cnt_reg == STAB_W'(SETTLE_CYCLES - 1)) begin
          state_next      = COMMA_SEARCH;
          gain_next       = GAIN_TRK;
          stab_cnt_next   = '0;
          search_cnt_next = '0;
        end else begin
          stab_cnt_next = stab_cnt_reg + STAB_W'(1);
        end
      end
      COMMA_SEARCH: begin
        // A comma outranks the slip decision on the same word.
        if (is_comma) begin
          state_next      = COMMA_VERIFY;
          comma_cnt_next  = COMMA_W'(1);
          gap_cnt_next    = '0;
          search_cnt_next = '0;
          aligned_next    = 1'b1;
        end else if (search_cnt_reg == SRCH_W'(SEARCH_WORDS - 1)) begin
          search_cnt_next = '0;
          bit_slip_next   = 1'b1;
          if (slip_cnt_reg == 4'(SLIP_ROTATIONS - 1)) begin
            state_next    = CDR_ACQ;
            gain_next     = GAIN_ACQ;
            slip_cnt_next = '0;
            stab_cnt_next = '0;
          end else begin
            state_next    = SLIP_HOLD;
            slip_cnt_next = slip_cnt_reg + 4'd1;
            wait_cnt_next = '0;
          end
        end else begin
          search_cnt_next = search_cnt_reg + SRCH_W'(1);
        end
      end
      SLIP_HOLD: begin
        if (wait_cnt_reg == WAIT_W'(SLIP_WAIT - 1)) begin
          state_next      = COMMA_SEARCH;
          wait_cnt_next   = '0;
          search_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      COMMA_VERIFY: begin
        if (DecodeErr) begin
          state_next      = COMMA_SEARCH;
          aligned_next    = 1'b0;
          search_cnt_next = '0;
        end else if (is_comma) begin
          gap_cnt_next = '0;
          if (comma_cnt_reg == COMMA_W'(LOCK_COMMAS - 1)) begin
            state_next    = LINK_UP;
            link_up_next  = 1'b1;
            slip_cnt_next = '0;
            win_cnt_next  = '0;
            err_cnt_next  = '0;
          end else begin
            comma_cnt_next = comma_cnt_reg + COMMA_W'(1);
          end
        end else if (gap_cnt_reg == SRCH_W'(SEARCH_WORDS - 1)) begin
          state_next      = COMMA_SEARCH;
          aligned_next    = 1'b0;
          search_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg + SRCH_W'(1);
        end
      end
      LINK_UP: begin
        win_cnt_next = win_cnt_reg + WIN_W'(1);
        // The wrap word opens the next window with its own error already counted.
        err_cnt_next = win_wrap ? ERR_W'(DecodeErr) : err_sum[ERR_W-1:0];
        if (err_sum >= (ERR_W+1)'(ERR_LIMIT)) begin
          state_next      = COMMA_SEARCH;
          link_up_next    = 1'b0;
          aligned_next    = 1'b0;
          search_cnt_next = '0;
        end
      end
      default: begin
        state_next = CDR_ACQ;
        gain_next  = GAIN_ACQ;
      end
    endcase
  end

  assign BitSlip   = bit_slip_reg;
  assign gainsel   = gain_reg;
  assign Aligned   = aligned_reg;
  assign LinkUp    = link_up_reg;
  assign state_dbg = state_reg;

`ifdef RX_LINK_STATS_EN
  logic [15:0] link_drops_reg;
  logic [15:0] slip_total_reg;

  always_ff @(posedge BitCLK_10 or negedge Reset) begin
    if (!Reset) begin
      link_drops_reg <= '0;
      slip_total_reg <= '0;
    end else begin
      if (state_reg == LINK_UP && state_next != LINK_UP && link_drops_reg != 16'hFFFF)
        link_drops_reg <= link_drops_reg + 16'd1;
      if (bit_slip_next && slip_total_reg != 16'hFFFF)
        slip_total_reg <= slip_total_reg + 16'd1;
    end
  end

  assign link_drops = link_drops_reg;
  assign slip_total = slip_total_reg;
`endif

endmodule

// File: tb/tb_rx_link_controller.sv
// Directed bench for rx_link_controller; models a SIPO whose word boundary
// starts three bit rotations away from the K28.5 alignment.
module tb_rx_link_controller;
  import serdes_pkg::*;

  localparam int SLIP_WAIT = 3;

  logic        clk = 1'b0;
  logic        Reset;
  logic [9:0]  RxParallel_10;
  logic        DecodeErr;
  logic [8:0]  phase_shift;
  logic        BitSlip;
  logic [1:0]  gainsel;
  logic        Aligned;
  logic        LinkUp;
  logic [2:0]  state_dbg;
`ifdef RX_LINK_STATS_EN
  logic [15:0] link_drops;
  logic [15:0] slip_total;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k = 0;
  int slips = 0;
  int last_slip = -1000;
  int aligned_cyc = -1;
  int commas = 0;
  bit no_comma = 1'b0;
  logic [9:0] filler = 10'b0101010101;

  rx_link_controller dut (
    .BitCLK_10     (clk),
    .Reset         (Reset),
    .RxParallel_10 (RxParallel_10),
    .DecodeErr     (DecodeErr),
    .phase_shift   (phase_shift),
    .BitSlip       (BitSlip),
    .gainsel       (gainsel),
    .Aligned       (Aligned),
    .LinkUp        (LinkUp),
    .state_dbg     (state_dbg)
`ifdef RX_LINK_STATS_EN
    ,
    .link_drops    (link_drops),
    .slip_total    (slip_total)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
    logic [19:0] d;
    d = {w, w} << r;
    return d[19:10];
  endfunction

  // One word: present the SIPO output, clock it, then observe outputs 1 ns later.
  task automatic step();
    int r;
    r = ((3 - slips) % 10 + 10) % 10;
    if (!no_comma && (k % 16 == 0)) begin
      RxParallel_10 = rotl(K28_5_RDN, r);
      if (r == 0) commas++;
    end else begin
      RxParallel_10 = filler;
    end
    @(posedge clk);
    #1;
    cyc++;
    k++;
    if (BitSlip === 1'b1) begin
      check("slip_gap", 32'(cyc - last_slip >= SLIP_WAIT + 1), 32'd1);
      slips++;
      last_slip = cyc;
    end
    if (Aligned === 1'b1 && aligned_cyc < 0) aligned_cyc = cyc;
  endtask

  task automatic do_reset();
    Reset         = 1'b0;
    DecodeErr     = 1'b0;
    phase_shift   = 9'd100;
    RxParallel_10 = '0;
    repeat (2) @(posedge clk);
    #1;
    Reset       = 1'b1;
    k           = 0;
    slips       = 0;
    last_slip   = -1000;
    aligned_cyc = -1;
    commas      = 0;
  endtask

  task automatic wait_linkup(input string tag);
    int n;
    n = 0;
    while (LinkUp !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    check(tag, 32'(LinkUp), 32'd1);
  endtask

  task automatic err_word();
    DecodeErr = 1'b1;
    step();
    DecodeErr = 1'b0;
  endtask

  initial begin
    int n;

    // Reset values
    do_reset();
    Reset = 1'b0;
    #2;
    check("rst_bitslip", 32'(BitSlip), 32'd0);
    check("rst_gainsel", 32'(gainsel), 32'd3);
    check("rst_aligned", 32'(Aligned), 32'd0);
    check("rst_linkup", 32'(LinkUp), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Phase toggling by 10 never settles
    do_reset();
    for (int i = 0; i < 100; i++) begin
      phase_shift = (i % 2 == 1) ? 9'd110 : 9'd100;
      step();
    end
    check("toggle_state", 32'(state_dbg), 32'd0);
    check("toggle_gain", 32'(gainsel), 32'd3);
    check("toggle_noslip", 32'(slips), 32'd0);

    // Constant phase: 64 stable words to leave CDR_ACQ
    do_reset();
    repeat (63) step();
    check("acq_gain63", 32'(gainsel), 32'd3);
    check("acq_state63", 32'(state_dbg), 32'd0);
    step();
    check("acq_gain64", 32'(gainsel), 32'd1);
    check("acq_state64", 32'(state_dbg), 32'd1);

    // No comma at all: 10 slips then back to CDR_ACQ
    no_comma = 1'b1;
    n = 0;
    while (slips < 10 && n < 1000) begin
      step();
      n++;
    end
    check("nocomma_slips", 32'(slips), 32'd10);
    check("nocomma_state", 32'(state_dbg), 32'd0);
    check("nocomma_gain", 32'(gainsel), 32'd3);
    repeat (20) step();
    check("nocomma_stop", 32'(slips), 32'd10);
    no_comma = 1'b0;

    // Boundary three rotations away
    do_reset();
    wait_linkup("lock_linkup");
    check("lock_slips", 32'(slips), 32'd3);
    check("lock_commas", 32'(commas), 32'd4);
    check("lock_aligned_first", 32'(aligned_cyc > 0 && aligned_cyc < cyc), 32'd1);
    check("lock_aligned", 32'(Aligned), 32'd1);
    check("lock_state", 32'(state_dbg), 32'd4);
    check("lock_gain", 32'(gainsel), 32'd1);

    // Seven errors in a window keep the link; the eighth drops it
    repeat (7) err_word();
    check("err7_linkup", 32'(LinkUp), 32'd1);
    repeat (3) step();
    check("err7_hold", 32'(LinkUp), 32'd1);
    err_word();
    check("err8_linkup", 32'(LinkUp), 32'd0);
    check("err8_state", 32'(state_dbg), 32'd1);
    check("err8_aligned", 32'(Aligned), 32'd0);
    check("err8_gain", 32'(gainsel), 32'd1);

    // Seven errors, window wrap, one more: no drop
    wait_linkup("relock_linkup");
    repeat (7) err_word();
    repeat (253) step();
    check("wrap_pre", 32'(LinkUp), 32'd1);
    err_word();
    repeat (4) step();
    check("wrap_linkup", 32'(LinkUp), 32'd1);
    check("wrap_state", 32'(state_dbg), 32'd4);

    // Asynchronous reset in LINK_UP
    #3;
    Reset = 1'b0;
    #1;
    check("async_bitslip", 32'(BitSlip), 32'd0);
    check("async_gain", 32'(gainsel), 32'd3);
    check("async_aligned", 32'(Aligned), 32'd0);
    check("async_linkup", 32'(LinkUp), 32'd0);
    check("async_state", 32'(state_dbg), 32'd0);

`ifdef RX_LINK_STATS_EN
    check("stats_drops_rst", 32'(link_drops), 32'd0);
    check("stats_slips_rst", 32'(slip_total), 32'd0);
    do_reset();
    wait_linkup("stats_linkup");
    check("stats_slips", 32'(slip_total), 32'd3);
    repeat (8) err_word();
    check("stats_drop_linkup", 32'(LinkUp), 32'd0);
    check("stats_drops", 32'(link_drops), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
